// File: rtl/cluster_pkg.sv
// Shared types and constants for the point clustering engine.
package cluster_pkg;

  localparam int N_PTS = 16;
  localparam int IDX_W = 4;
  localparam int LBL_W = 4;

  localparam logic [LBL_W-1:0] LBL_NONE = '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN
  } sched_state_t;

endpackage

// File: rtl/lbl_port_mux.sv
// Label RAM port selector: clear sweep, clustering FSM or host reader.
import cluster_pkg::*;

module lbl_port_mux #(
  parameter int AW = IDX_W,
  parameter int LW = LBL_W
) (
  input  sched_state_t    state_i,
  input  logic [AW-1:0]   ca_i,
  input  logic            fsm_we_i,
  input  logic [AW-1:0]   fsm_waddr_i,
  input  logic [LW-1:0]   fsm_wlabel_i,
  input  logic            host_req_i,
  input  logic [AW-1:0]   host_addr_i,
  output logic            we_o,
  output logic [AW-1:0]   waddr_o,
  output logic [LW-1:0]   wdata_o,
  output logic [AW-1:0]   raddr_o,
  output logic            gnt_o
);

  always_comb begin
    we_o    = 1'b0;
    waddr_o = '0;
    wdata_o = LBL_NONE;
    raddr_o = '0;
    gnt_o   = 1'b0;
    unique case (state_i)
      S_IDLE: begin
        gnt_o   = host_req_i;
        raddr_o = host_addr_i;
      end
      S_CLEAR: begin
        we_o    = 1'b1;
        waddr_o = ca_i;
      end
      S_RUN, S_DRAIN: begin
        we_o    = fsm_we_i;
        waddr_o = fsm_waddr_i;
        wdata_o = fsm_wlabel_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cluster_sched.sv
// Run sequencer and label RAM arbiter for the clustering engine.
// Optional RUN watchdog: define CLUSTER_SCHED_WDOG_EN.
import cluster_pkg::*;

module cluster_sched #(
  parameter int N        = N_PTS,
  parameter int AW       = IDX_W,
  parameter int LW       = LBL_W,
  parameter int WDOG_CYC = N*N+8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [LW-1:0] nclusters,
  output logic          fsm_rst,
  input  logic          fsm_done,
  input  logic          fsm_we,
  input  logic [AW-1:0] fsm_waddr,
  input  logic [LW-1:0] fsm_wlabel,
  output logic          lbl_we,
  output logic [AW-1:0] lbl_waddr,
  output logic [LW-1:0] lbl_wdata,
  output logic [AW-1:0] lbl_raddr,
  input  logic [LW-1:0] lbl_rdata,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_gnt,
  output logic          rd_valid,
  output logic [LW-1:0] rd_data
);

  sched_state_t  state_q;
  logic [AW-1:0] ca_q;
  logic [LW-1:0] ncl_q;
  logic          busy_q;
  logic          done_q;
  logic          fsm_rst_q;
  logic          rd_valid_q;
  logic          fsm_wr_live;

  // A host request in the cycle start is seen loses to the run.
  lbl_port_mux #(.AW(AW), .LW(LW)) u_mux (
    .state_i      (state_q),
    .ca_i         (ca_q),
    .fsm_we_i     (fsm_we),
    .fsm_waddr_i  (fsm_waddr),
    .fsm_wlabel_i (fsm_wlabel),
    .host_req_i   (rd_req & ~start),
    .host_addr_i  (rd_addr),
    .we_o         (lbl_we),
    .waddr_o      (lbl_waddr),
    .wdata_o      (lbl_wdata),
    .raddr_o      (lbl_raddr),
    .gnt_o        (rd_gnt)
  );

  assign fsm_wr_live = fsm_we &
    ((state_q == S_RUN) | (state_q == S_DRAIN));

`ifdef CLUSTER_SCHED_WDOG_EN
  localparam int WDW = $clog2(WDOG_CYC + 1);
  logic [WDW-1:0] wd_q;
  logic           err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ca_q       <= '0;
      ncl_q      <= LBL_NONE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fsm_rst_q  <= 1'b1;
      rd_valid_q <= 1'b0;
`ifdef CLUSTER_SCHED_WDOG_EN
      wd_q       <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      done_q     <= 1'b0;
      rd_valid_q <= rd_gnt;
`ifdef CLUSTER_SCHED_WDOG_EN
      err_q      <= 1'b0;
`endif
      // Labels never exceed 2^LW-1, so max tracking cannot wrap.
      if (fsm_wr_live && (fsm_wlabel > ncl_q))
        ncl_q <= fsm_wlabel;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_CLEAR;
            ca_q    <= '0;
            ncl_q   <= LBL_NONE;
            busy_q  <= 1'b1;
          end
        end
        S_CLEAR: begin
          ca_q <= ca_q + 1'b1;
          if (ca_q == AW'(N-1)) begin
            state_q   <= S_RUN;
            fsm_rst_q <= 1'b0;
`ifdef CLUSTER_SCHED_WDOG_EN
            wd_q      <= '0;
`endif
          end
        end
        S_RUN: begin
          if (fsm_done) begin
            state_q   <= S_DRAIN;
            fsm_rst_q <= 1'b1;
          end
`ifdef CLUSTER_SCHED_WDOG_EN
          else if (wd_q == WDW'(WDOG_CYC-1)) begin
            state_q   <= S_IDLE;
            fsm_rst_q <= 1'b1;
            busy_q    <= 1'b0;
            err_q     <= 1'b1;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
`endif
        end
        S_DRAIN: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign nclusters = ncl_q;
  assign fsm_rst   = fsm_rst_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_valid_q ? lbl_rdata : LBL_NONE;

endmodule

// File: tb/tb_cluster_sched.sv
// Directed bench for cluster_sched with a behavioural label RAM.
module tb_cluster_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       busy, done, err;
  logic [3:0] nclusters;
  logic       fsm_rst, fsm_done, fsm_we;
  logic [3:0] fsm_waddr, fsm_wlabel;
  logic       lbl_we;
  logic [3:0] lbl_waddr, lbl_wdata, lbl_raddr;
  logic [3:0] rdata_q;
  logic       rd_req, rd_gnt, rd_valid;
  logic [3:0] rd_addr, rd_data;

  logic [3:0] mem [16];
  logic [3:0] elab [16];
  logic [3:0] wl [5];
  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  cluster_sched dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .nclusters  (nclusters),
    .fsm_rst    (fsm_rst),
    .fsm_done   (fsm_done),
    .fsm_we     (fsm_we),
    .fsm_waddr  (fsm_waddr),
    .fsm_wlabel (fsm_wlabel),
    .lbl_we     (lbl_we),
    .lbl_waddr  (lbl_waddr),
    .lbl_wdata  (lbl_wdata),
    .lbl_raddr  (lbl_raddr),
    .lbl_rdata  (rdata_q),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_gnt     (rd_gnt),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data)
  );

  always @(posedge clk) begin
    if (lbl_we) mem[lbl_waddr] <= lbl_wdata;
    rdata_q <= mem[lbl_raddr];
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    fsm_done = 1'b0; fsm_we = 1'b0;
    fsm_waddr = '0; fsm_wlabel = '0;
    rd_req = 1'b0; rd_addr = '0;
    for (int i = 0; i < 16; i++) begin
      mem[i]  = 4'hF;
      elab[i] = 4'h0;
    end
    wl[0] = 4'd1; wl[1] = 4'd1; wl[2] = 4'd2;
    wl[3] = 4'd3; wl[4] = 4'd3;
    for (int i = 0; i < 5; i++) elab[i] = wl[i];

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_fsm_rst", fsm_rst, 1);
    chk("rst_ncl", nclusters, 0);
    chk("rst_lbl_we", lbl_we, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);

    // reset in the middle of CLEAR
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("clr0_busy", busy, 1);
    chk("clr0_we", lbl_we, 1);
    chk("clr0_addr", lbl_waddr, 0);
    repeat (2) @(negedge clk);
    chk("clr2_addr", lbl_waddr, 2);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_we", lbl_we, 0);
    chk("midrst_fsm_rst", fsm_rst, 1);
    chk("midrst_ncl", nclusters, 0);
    rst = 1'b0;
    @(negedge clk);

    // normal run
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("clr_we", lbl_we, 1);
      chk("clr_addr", lbl_waddr, 32'(i));
      chk("clr_data", lbl_wdata, 0);
      chk("clr_fsm_rst", fsm_rst, 1);
      @(negedge clk);
    end
    chk("run_fsm_rst", fsm_rst, 0);
    chk("run_busy", busy, 1);

    rd_req = 1'b1; rd_addr = 4'd5; start = 1'b1;
    #1 chk("run_gnt", rd_gnt, 0);
    @(negedge clk);
    rd_req = 1'b0; start = 1'b0;
    chk("run_rd_valid", rd_valid, 0);
    chk("run_restart_busy", busy, 1);
    chk("run_restart_frst", fsm_rst, 0);

    for (int k = 0; k < 5; k++) begin
      fsm_we = 1'b1; fsm_waddr = 4'(k); fsm_wlabel = wl[k];
      #1;
      chk("fwd_we", lbl_we, 1);
      chk("fwd_addr", lbl_waddr, 32'(k));
      chk("fwd_data", lbl_wdata, 32'(wl[k]));
      @(negedge clk);
    end
    fsm_we = 1'b0;
    chk("run_ncl", nclusters, 3);

    fsm_done = 1'b1;
    @(negedge clk);
    fsm_done = 1'b0;
    chk("drain_frst", fsm_rst, 1);
    chk("drain_busy", busy, 1);
    chk("drain_done", done, 0);
    @(negedge clk);
    chk("end_done", done, 1);
    chk("end_busy", busy, 0);
    chk("end_ncl", nclusters, 3);
    @(negedge clk);
    chk("end_done_pulse", done, 0);

    fsm_we = 1'b1; fsm_waddr = 4'd7; fsm_wlabel = 4'd9;
    #1 chk("idle_fsm_we", lbl_we, 0);
    @(negedge clk);
    fsm_we = 1'b0;
    chk("idle_ncl_hold", nclusters, 3);

    // back-to-back readout
    for (int i = 0; i < 16; i++) begin
      rd_req = 1'b1; rd_addr = 4'(i);
      #1;
      chk("rd_gnt", rd_gnt, 1);
      chk("rd_raddr", lbl_raddr, 32'(i));
      if (i > 0) begin
        chk("rd_valid", rd_valid, 1);
        chk("rd_data", rd_data, 32'(elab[i-1]));
      end
      @(negedge clk);
    end
    rd_req = 1'b0;
    chk("rd_valid_last", rd_valid, 1);
    chk("rd_data_last", rd_data, 32'(elab[15]));
    @(negedge clk);
    chk("rd_valid_off", rd_valid, 0);

    // start beats a simultaneous host read
    start = 1'b1; rd_req = 1'b1; rd_addr = 4'd3;
    #1 chk("start_gnt", rd_gnt, 0);
    @(negedge clk);
    start = 1'b0; rd_req = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_rd_valid", rd_valid, 0);
    chk("start_ncl_clr", nclusters, 0);

    // late write during DRAIN
    repeat (16) @(negedge clk);
    chk("late_run", fsm_rst, 0);
    fsm_we = 1'b1; fsm_waddr = 4'd0; fsm_wlabel = 4'd2;
    @(negedge clk);
    fsm_we = 1'b0; fsm_done = 1'b1;
    @(negedge clk);
    fsm_done = 1'b0;
    fsm_we = 1'b1; fsm_waddr = 4'd9; fsm_wlabel = 4'd5;
    #1;
    chk("late_we", lbl_we, 1);
    chk("late_data", lbl_wdata, 5);
    @(negedge clk);
    fsm_we = 1'b0;
    chk("late_done", done, 1);
    chk("late_ncl", nclusters, 5);
    rd_req = 1'b1; rd_addr = 4'd9;
    @(negedge clk);
    rd_req = 1'b0;
    chk("late_rd", rd_data, 5);

`ifdef CLUSTER_SCHED_WDOG_EN
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (16) @(negedge clk);
    chk("wd_run", fsm_rst, 0);
    repeat (263) @(negedge clk);
    chk("wd_early", err, 0);
    @(negedge clk);
    chk("wd_err", err, 1);
    chk("wd_done", done, 0);
    chk("wd_busy", busy, 0);
    chk("wd_frst", fsm_rst, 1);
    @(negedge clk);
    chk("wd_err_pulse", err, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
